// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Fixed 34-cycle schedule: accept, 32 shift-add / shift-subtract steps, sign fix-up.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        WrHI,
  input  logic        WrLO,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        neg_res_q;
  logic        neg_rem_q;
  logic [31:0] opnd_q;
  logic [63:0] acc_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    // Op[0] selects the signed variants
    a_neg = Op[0] & A[31];
    b_neg = Op[0] & B[31];
    a_mag = a_neg ? (32'd0 - A) : A;
    b_mag = b_neg ? (32'd0 - B) : B;

    // Multiply: acc = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};

    prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (Start) begin
            is_div_q  <= Op[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            opnd_q    <= Op[1] ? b_mag : a_mag;
            acc_q     <= {32'd0, (Op[1] ? a_mag : b_mag)};
            cnt_q     <= 5'd0;
            busy_q    <= 1'b1;
            state_q   <= StCalc;
          end else begin
            if (WrHI) hi_q <= WData;
            if (WrLO) lo_q <= WData;
          end
        end
        StCalc: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= StFix;
        end
        StFix: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        WrHI;
  logic        WrLO;
  logic [31:0] WData;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  int errs   = 0;
  int checks = 0;

  // Results of the most recent do_op
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  int          r_lat;
  int          r_busy;
  bit          r_overlap;
  bit          r_held;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk  (clk),
    .rst  (rst),
    .Start(Start),
    .Op   (Op),
    .A    (A),
    .B    (B),
    .WrHI (WrHI),
    .WrLO (WrLO),
    .WData(WData),
    .Busy (Busy),
    .Done (Done),
    .HI   (HI),
    .LO   (LO)
  );

  // Returns {HI, LO} as the architecture defines them
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: return ua * ub;
      2'd1: return 64'(sa * sb);
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'd0) return {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Called and returns at a negedge; Start is asserted for exactly one edge
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi0, lo0;
    hi0 = HI;
    lo0 = LO;
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    @(negedge clk);
    Start = 1'b0;
    WrHI = 1'b0;
    WrLO = 1'b0;
    Op = 2'($urandom);
    A = $urandom;
    B = $urandom;
    r_lat = 1;
    r_busy = Busy ? 1 : 0;
    r_overlap = Busy && Done;
    r_held = 1'b1;
    while (!Done && r_lat < 100) begin
      if (Busy && (HI !== hi0 || LO !== lo0)) r_held = 1'b0;
      @(negedge clk);
      r_lat++;
      if (Busy) r_busy++;
      if (Busy && Done) r_overlap = 1'b1;
    end
    r_hi = HI;
    r_lo = LO;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    Start = 1'b0;
    Op = 2'd0;
    A = 32'd0;
    B = 32'd0;
    WrHI = 1'b0;
    WrLO = 1'b0;
    WData = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({Busy, Done, HI, LO} !== 66'd0) begin
      errs++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, want all zero",
               Busy, Done, HI, LO);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu_full();
    do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks++;
    if ({r_hi, r_lo} !== 64'hFFFFFFFE_00000001) begin
      errs++;
      $display("FAIL multu_max: got %h_%h, want fffffffe_00000001", r_hi, r_lo);
    end
    checks++;
    if (r_lat !== 34) begin
      errs++;
      $display("FAIL multu_latency: got %0d, want 34", r_lat);
    end
    checks++;
    if (r_busy !== 33) begin
      errs++;
      $display("FAIL multu_busy_cycles: got %0d, want 33", r_busy);
    end
    checks++;
    if (r_overlap || !r_held) begin
      errs++;
      $display("FAIL multu_busy_done_hold: got overlap=%b held=%b, want 0 1", r_overlap, r_held);
    end
    @(negedge clk);
    checks++;
    if ({Busy, Done} !== 2'b00) begin
      errs++;
      $display("FAIL done_width: got busy=%b done=%b one cycle later, want 0 0", Busy, Done);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops[7] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [31:0] as[7]  = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'h64, 32'h1234, 32'h80000000,
                            32'hFFFFFFF9, 32'h7};
    logic [31:0] bs[7]  = '{32'h5, 32'h2, 32'h7, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic [63:0] ex[7]  = '{64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFF_FFFFFFFD, 64'h00000002_0000000E,
                            64'h00001234_FFFFFFFF, 64'h00000000_80000000,
                            64'hFFFFFFF9_00000001, 64'h00000007_FFFFFFFF};
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], as[i], bs[i]);
      checks++;
      if ({r_hi, r_lo} !== ex[i] || r_lat !== 34) begin
        errs++;
        $display("FAIL directed_%0d: op=%0d a=%h b=%h got %h_%h lat=%0d, want %h lat=34",
                 i, ops[i], as[i], bs[i], r_hi, r_lo, r_lat, ex[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    logic [31:0] lo0;
    lo0 = LO;
    Start = 1'b1;
    Op = 2'd0;
    A = 32'd2;
    B = 32'd3;
    @(negedge clk);
    cyc = 1;
    while (!Done && cyc < 100) begin
      Start = (cyc == 4);
      if (cyc == 4) begin
        Op = 2'd2;
        A = 32'd9;
        B = 32'd3;
      end else if (cyc > 4) begin
        A = $urandom;
        B = $urandom;
      end
      WrLO = (cyc == 10);
      WData = 32'hAAAA5555;
      if (cyc == 11) begin
        checks++;
        if (LO !== lo0) begin
          errs++;
          $display("FAIL busy_wrlo: got lo=%h while busy, want %h", LO, lo0);
        end
      end
      @(negedge clk);
      cyc++;
    end
    Start = 1'b0;
    WrLO = 1'b0;
    checks++;
    if (cyc !== 34 || HI !== 32'd0 || LO !== 32'd6) begin
      errs++;
      $display("FAIL busy_start_ignored: got lat=%0d hi=%h lo=%h, want 34 0 6", cyc, HI, LO);
    end
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin
      errs++;
      $display("FAIL start_not_queued: got busy=%b after done, want 0", Busy);
    end
  endtask

  task automatic test_reset_abort();
    Start = 1'b1;
    Op = 2'd0;
    A = 32'd7;
    B = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({Busy, Done, HI, LO} !== 66'd0) begin
      errs++;
      $display("FAIL abort_reset: got busy=%b done=%b hi=%h lo=%h, want all zero",
               Busy, Done, HI, LO);
    end
    repeat (40) @(negedge clk);
    checks++;
    if ({Busy, Done, HI, LO} !== 66'd0) begin
      errs++;
      $display("FAIL abort_no_resume: got busy=%b done=%b hi=%h lo=%h, want all zero",
               Busy, Done, HI, LO);
    end
    do_op(2'd0, 32'd7, 32'd9);
    checks++;
    if ({r_hi, r_lo} !== 64'd63 || r_lat !== 34) begin
      errs++;
      $display("FAIL abort_restart: got %h_%h lat=%0d, want 0_3f lat=34", r_hi, r_lo, r_lat);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo0;
    int cyc;
    lo0 = LO;
    WrHI = 1'b1;
    WData = 32'h12345678;
    @(negedge clk);
    WrHI = 1'b0;
    checks++;
    if (HI !== 32'h12345678 || LO !== lo0) begin
      errs++;
      $display("FAIL mthi: got hi=%h lo=%h, want 12345678 %h", HI, LO, lo0);
    end
    WrLO = 1'b1;
    WData = 32'hCAFEF00D;
    @(negedge clk);
    WrLO = 1'b0;
    checks++;
    if (HI !== 32'h12345678 || LO !== 32'hCAFEF00D) begin
      errs++;
      $display("FAIL mtlo: got hi=%h lo=%h, want 12345678 cafef00d", HI, LO);
    end
    WrHI = 1'b1;
    WrLO = 1'b1;
    WData = 32'h0BADBEEF;
    @(negedge clk);
    WrHI = 1'b0;
    WrLO = 1'b0;
    checks++;
    if (HI !== 32'h0BADBEEF || LO !== 32'h0BADBEEF) begin
      errs++;
      $display("FAIL mthi_mtlo_both: got hi=%h lo=%h, want 0badbeef both", HI, LO);
    end
    // Start and WrLO in the same cycle: the write must be dropped
    Start = 1'b1;
    WrLO = 1'b1;
    WData = 32'hAAAA5555;
    Op = 2'd0;
    A = 32'd3;
    B = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    WrLO = 1'b0;
    checks++;
    if (LO !== 32'h0BADBEEF || Busy !== 1'b1) begin
      errs++;
      $display("FAIL start_wins: got lo=%h busy=%b, want 0badbeef 1", LO, Busy);
    end
    cyc = 1;
    while (!Done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (HI !== 32'd0 || LO !== 32'd15 || cyc !== 34) begin
      errs++;
      $display("FAIL start_wins_result: got hi=%h lo=%h lat=%0d, want 0 f 34", HI, LO, cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    do_op(2'd1, 32'h80000000, 32'h80000000);
    checks++;
    if ({r_hi, r_lo} !== 64'h40000000_00000000) begin
      errs++;
      $display("FAIL b2b_first: got %h_%h, want 40000000_00000000", r_hi, r_lo);
    end
    // Start asserted in the Done cycle
    do_op(2'd3, 32'h80000000, 32'h00000003);
    exp = ref_model(2'd3, 32'h80000000, 32'h00000003);
    checks++;
    if ({r_hi, r_lo} !== exp || r_lat !== 34 || r_busy !== 33) begin
      errs++;
      $display("FAIL b2b_second: got %h_%h lat=%0d busy=%0d, want %h lat=34 busy=33",
               r_hi, r_lo, r_lat, r_busy, exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      exp = ref_model(op, a, b);
      do_op(op, a, b);
      checks++;
      if ({r_hi, r_lo} !== exp || r_lat !== 34 || r_busy !== 33 || r_overlap || !r_held) begin
        errs++;
        $display("FAIL random_%0d: op=%0d a=%h b=%h got %h_%h lat=%0d busy=%0d ovl=%b held=%b, want %h lat=34 busy=33",
                 i, op, a, b, r_hi, r_lo, r_lat, r_busy, r_overlap, r_held, exp);
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_multu_full();
    test_directed();
    test_busy_ignore();
    test_reset_abort();
    test_mthi_mtlo();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers, for the multi-cycle MIPS datapath. It executes MULT, MULTU, DIV and DIVU over a fixed 34-cycle schedule and holds results in HI/LO. MFHI/MFLO read HI/LO, and MTHI/MTLO write them. HI and LO feed the writeback-select 32-bit 2:1 mux, which chooses between the ALU result and the HI/LO value before the register file.

## Interface
- No parameters; datapath width fixed at 32.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- Start  input  1  request an operation; sampled only when Busy=0
- Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with Start
- A  input  32  multiplicand / dividend (rs); sampled with Start
- B  input  32  multiplier / divisor (rt); sampled with Start
- WrHI  input  1  MTHI: HI <= WData
- WrLO  input  1  MTLO: LO <= WData
- WData  input  32  write data for WrHI/WrLO
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse: HI/LO just updated by an operation
- HI  output  32  high product word / remainder
- LO  output  32  low product word / quotient

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - Start=1 latches Op, |A|, |B| and the sign flags, clears the counter, and moves to CALC.
  - For signed ops, magnitudes are two's-complement absolute values. For unsigned ops, A and B are taken as-is.
- CALC: 32 iterations, one per clock; counter 0..31.
  - Multiply uses shift-add on a 64-bit accumulator.
  - Divide uses restoring shift-subtract on a 33-bit partial remainder.
  - After iteration 31, move to FIX.
- FIX:
  - Sign correction:
    - MULT: 64-bit result negated if sign(A)^sign(B).
    - DIV: quotient negated if sign(A)^sign(B); remainder negated if sign(A).
  - Writes HI/LO, pulses Done, returns to IDLE.
- Inputs A, B, Op are ignored outside the Start-acceptance cycle.
- Start while Busy=1 is ignored; it is not queued.
- WrHI/WrLO:
  - Honoured only in IDLE with Start=0.
  - Ignored while Busy=1 or when Start=1 in the same cycle (Start wins).
  - WrHI and WrLO together write both registers.
- HI/LO hold their previous values throughout CALC; they change only on FIX, WrHI/WrLO, or reset.
- Divide by zero produces no exception; the result is whatever the algorithm yields:
  - DIVU: LO=FFFFFFFF, HI=A.
  - DIV: LO=FFFFFFFF if A≥0, else 00000001; HI=A.
- DIV 80000000 / FFFFFFFF: LO=80000000, HI=00000000.
- MULT/MULTU produce the full 64-bit result {HI,LO} with no overflow.

## Timing
- Reset values: HI=0, LO=0, Busy=0, Done=0, state IDLE, counter 0.
- rst at any time, including mid-CALC or FIX, aborts the operation next edge with no HI/LO update and no Done.
- With Start accepted at edge E:
  - Busy=1 after edges E..E+32 (33 cycles).
  - At edge E+33 (FIX), HI/LO are updated, Done=1 and Busy=0.
  - Done drops after edge E+34 unless another op completes.
- Result latency is 34 cycles, fixed for all Ops and operands.
- Busy and Done are never high together. Both are registered outputs.
- Start may be asserted in the Done cycle and is accepted (state is IDLE).
- HI/LO writes via WrHI/WrLO are visible the cycle after the edge.

## Test plan
- Reset, then MULTU A=FFFFFFFF B=FFFFFFFF -> after 34 cycles HI=FFFFFFFE, LO=00000001; Done is high exactly one cycle; Busy was high 33 cycles.
- MULT A=FFFFFFFD (-3) B=00000005 -> HI=FFFFFFFF, LO=FFFFFFF1; then DIV A=FFFFFFF9 (-7) B=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF.
- DIVU A=00000064 B=00000007 -> LO=0000000E, HI=00000002; DIVU A=00001234 B=0 -> LO=FFFFFFFF, HI=00001234.
- Start MULTU 2×3. Then assert Start with Op=DIVU, A=9, B=3 at cycle 5, and change A/B during Busy -> second Start ignored; result HI=0, LO=6 at the original completion cycle. WrLO=1 WData=AAAA5555 while Busy -> LO not written.
- Start MULTU 7×7, assert rst at cycle 10 -> next cycle HI=LO=0, Busy=Done=0. A new Start after release completes normally in 34 cycles.
- In IDLE:
  - WrHI=1 WData=12345678 -> HI=12345678.
  - WrLO=1 with Start=1 in the same cycle -> write dropped; op result lands in HI/LO.
  - Start in the Done cycle -> accepted; Busy=1 next cycle.
